// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and source encodings for the common-data-bus arbiter.
// The source enum also serves as the one-bit last-grant arbitration state.
package cdb_arbiter_pkg;

    localparam int ROB_POS_W = 4;
    localparam int DATA_W    = 32;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side handshakes and broadcast bus of the CDB arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface cdb_arbiter_if #(
    parameter int ROB_POS_W = cdb_arbiter_pkg::ROB_POS_W,
    parameter int DATA_W    = cdb_arbiter_pkg::DATA_W
);
    logic                 alu_valid;
    logic                 alu_ready;
    logic [ROB_POS_W-1:0] alu_rob_pos;
    logic [DATA_W-1:0]    alu_val;
    logic                 alu_jump;
    logic [DATA_W-1:0]    alu_pc;

    logic                 lsb_valid;
    logic                 lsb_ready;
    logic [ROB_POS_W-1:0] lsb_rob_pos;
    logic [DATA_W-1:0]    lsb_val;

    logic                 cdb_valid;
    logic                 cdb_src;
    logic [ROB_POS_W-1:0] cdb_rob_pos;
    logic [DATA_W-1:0]    cdb_val;
    logic                 cdb_jump;
    logic [DATA_W-1:0]    cdb_pc;
    logic [15:0]          conflict_cnt;

    modport slave (
        input  alu_valid, alu_rob_pos, alu_val, alu_jump, alu_pc,
        input  lsb_valid, lsb_rob_pos, lsb_val,
        output alu_ready, lsb_ready,
        output cdb_valid, cdb_src, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc, conflict_cnt
    );

    modport master (
        output alu_valid, alu_rob_pos, alu_val, alu_jump, alu_pc,
        output lsb_valid, lsb_rob_pos, lsb_val,
        input  alu_ready, lsb_ready,
        input  cdb_valid, cdb_src, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc, conflict_cnt
    );

endinterface

// File: rtl/cdb_arbiter_result_fifo.sv
// Small circular queue holding one producer's pending results.
// DEPTH must be a power of two (at least 2) so the pointers wrap naturally.
module result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (i_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) r_mem[r_wrPtr] <= i_data;
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_count = r_count;

endmodule

// File: rtl/cdb_arbiter.sv
// Serialises ALU and LSB results onto a single registered broadcast bus,
// with per-source queues, empty-queue bypass and alternating conflict priority.
module cdb_arbiter #(
    parameter int ROB_POS_W = cdb_arbiter_pkg::ROB_POS_W,
    parameter int DATA_W    = cdb_arbiter_pkg::DATA_W,
    parameter int DEPTH     = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_rdy,
    input  logic                i_rollback,
    cdb_arbiter_if.slave        bus
);
    import cdb_arbiter_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ALU_W = ROB_POS_W + 2 * DATA_W + 1;
    localparam int LSB_W = ROB_POS_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ALU_W-1:0] w_aluIn, w_aluHead, w_aluSel;
    logic [LSB_W-1:0] w_lsbIn, w_lsbHead, w_lsbSel;
    logic [CNT_W-1:0] w_aluCount, w_lsbCount;
    logic w_aluReady, w_lsbReady, w_aluAccept, w_lsbAccept;
    logic w_aluNonEmpty, w_lsbNonEmpty, w_aluElig, w_lsbElig, w_both;
    logic w_grantAlu, w_grantLsb, w_aluPush, w_lsbPush, w_aluPop, w_lsbPop, w_flush;

    src_e                 r_lastGrant;
    logic                 r_cdbValid;
    src_e                 r_cdbSrc;
    logic [ROB_POS_W-1:0] r_cdbRobPos;
    logic [DATA_W-1:0]    r_cdbVal;
    logic                 r_cdbJump;
    logic [DATA_W-1:0]    r_cdbPc;
    logic [15:0]          r_conflictCnt;

    assign w_aluIn = {bus.alu_rob_pos, bus.alu_val, bus.alu_jump, bus.alu_pc};
    assign w_lsbIn = {bus.lsb_rob_pos, bus.lsb_val};

    assign w_aluReady    = i_rdy && (w_aluCount < FULL);
    assign w_lsbReady    = i_rdy && (w_lsbCount < FULL);
    assign w_aluAccept   = bus.alu_valid && w_aluReady && !i_rollback;
    assign w_lsbAccept   = bus.lsb_valid && w_lsbReady && !i_rollback;
    assign w_aluNonEmpty = (w_aluCount != '0);
    assign w_lsbNonEmpty = (w_lsbCount != '0);
    assign w_aluElig     = w_aluNonEmpty || w_aluAccept;
    assign w_lsbElig     = w_lsbNonEmpty || w_lsbAccept;
    assign w_both        = w_aluElig && w_lsbElig;

    // On a conflict the source not granted last time wins.
    assign w_grantLsb = i_rdy && !i_rollback && w_lsbElig && (!w_aluElig || r_lastGrant == SRC_ALU);
    assign w_grantAlu = i_rdy && !i_rollback && w_aluElig && !w_grantLsb;

    // A granted empty queue bypasses its input; everything else accepted is queued.
    assign w_aluPop  = w_grantAlu && w_aluNonEmpty;
    assign w_lsbPop  = w_grantLsb && w_lsbNonEmpty;
    assign w_aluPush = w_aluAccept && !(w_grantAlu && !w_aluNonEmpty);
    assign w_lsbPush = w_lsbAccept && !(w_grantLsb && !w_lsbNonEmpty);
    assign w_flush   = i_rdy && i_rollback;
    assign w_aluSel  = w_aluNonEmpty ? w_aluHead : w_aluIn;
    assign w_lsbSel  = w_lsbNonEmpty ? w_lsbHead : w_lsbIn;

    result_fifo #(.WIDTH(ALU_W), .DEPTH(DEPTH)) u_aluFifo (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(w_flush),
        .i_push(w_aluPush), .i_data(w_aluIn), .i_pop(w_aluPop),
        .o_head(w_aluHead), .o_count(w_aluCount)
    );

    result_fifo #(.WIDTH(LSB_W), .DEPTH(DEPTH)) u_lsbFifo (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(w_flush),
        .i_push(w_lsbPush), .i_data(w_lsbIn), .i_pop(w_lsbPop),
        .o_head(w_lsbHead), .o_count(w_lsbCount)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lastGrant   <= SRC_ALU;
            r_cdbValid    <= 1'b0;
            r_cdbSrc      <= SRC_ALU;
            r_cdbRobPos   <= '0;
            r_cdbVal      <= '0;
            r_cdbJump     <= 1'b0;
            r_cdbPc       <= '0;
            r_conflictCnt <= '0;
        end else if (i_rdy) begin
            if (i_rollback) begin
                r_cdbValid <= 1'b0;
            end else begin
                r_cdbValid <= w_grantAlu || w_grantLsb;
                if (w_grantLsb) begin
                    r_cdbSrc                <= SRC_LSB;
                    {r_cdbRobPos, r_cdbVal} <= w_lsbSel;
                    r_cdbJump               <= 1'b0;
                    r_cdbPc                 <= '0;
                end else if (w_grantAlu) begin
                    r_cdbSrc                                     <= SRC_ALU;
                    {r_cdbRobPos, r_cdbVal, r_cdbJump, r_cdbPc} <= w_aluSel;
                end
                if (w_both) begin
                    r_lastGrant <= w_grantLsb ? SRC_LSB : SRC_ALU;
                    if (r_conflictCnt != 16'hFFFF) r_conflictCnt <= r_conflictCnt + 16'd1;
                end
            end
        end
    end

    assign bus.alu_ready    = w_aluReady;
    assign bus.lsb_ready    = w_lsbReady;
    assign bus.cdb_valid    = r_cdbValid;
    assign bus.cdb_src      = r_cdbSrc;
    assign bus.cdb_rob_pos  = r_cdbRobPos;
    assign bus.cdb_val      = r_cdbVal;
    assign bus.cdb_jump     = r_cdbJump;
    assign bus.cdb_pc       = r_cdbPc;
    assign bus.conflict_cnt = r_conflictCnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized bench for cdb_arbiter, checked against a queue-based
// model of the per-source ordering, bypass and alternating-priority rules.
module tb_cdb_arbiter;

    localparam int ROB_W = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [ROB_W-1:0] rob;
        logic [DW-1:0]    val;
        logic             jump;
        logic [DW-1:0]    pc;
    } entry_t;

    logic clk;
    logic rstN;
    logic rdy;
    logic rollback;

    cdb_arbiter_if #(.ROB_POS_W(ROB_W), .DATA_W(DW)) bus ();

    cdb_arbiter #(.ROB_POS_W(ROB_W), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rstN), .i_rdy(rdy), .i_rollback(rollback), .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    entry_t aluQ[$];
    entry_t lsbQ[$];
    bit     lastWasLsb;
    entry_t expEntry;
    bit     expValid;
    bit     expSrc;
    int     expCnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkBus(input string tag);
        checkOutput({tag, ".valid"}, 64'(bus.cdb_valid), 64'(expValid));
        checkOutput({tag, ".src"}, 64'(bus.cdb_src), 64'(expSrc));
        checkOutput({tag, ".rob"}, 64'(bus.cdb_rob_pos), 64'(expEntry.rob));
        checkOutput({tag, ".val"}, 64'(bus.cdb_val), 64'(expEntry.val));
        checkOutput({tag, ".jump"}, 64'(bus.cdb_jump), 64'(expEntry.jump));
        checkOutput({tag, ".pc"}, 64'(bus.cdb_pc), 64'(expEntry.pc));
        checkOutput({tag, ".cnt"}, 64'(bus.conflict_cnt), 64'(expCnt));
    endtask

    task automatic resetModel();
        aluQ.delete();
        lsbQ.delete();
        lastWasLsb = 1'b0;
        expEntry   = '0;
        expValid   = 1'b0;
        expSrc     = 1'b0;
        expCnt     = 0;
    endtask

    // One clock of stimulus: drive, check ready, advance the model, check the bus.
    task automatic applyStimulus(input string tag,
                                 input bit aV, input int aRob, input int aVal, input bit aJ, input int aPc,
                                 input bit lV, input int lRob, input int lVal,
                                 input bit rdyIn, input bit rbIn);
        bit aRdyExp, lRdyExp, aAcc, lAcc, pickLsb;
        entry_t e;
        bus.alu_valid   = aV;
        bus.alu_rob_pos = ROB_W'(aRob);
        bus.alu_val     = DW'(aVal);
        bus.alu_jump    = aJ;
        bus.alu_pc      = DW'(aPc);
        bus.lsb_valid   = lV;
        bus.lsb_rob_pos = ROB_W'(lRob);
        bus.lsb_val     = DW'(lVal);
        rdy             = rdyIn;
        rollback        = rbIn;
        #1;
        aRdyExp = rdyIn && (aluQ.size() < DEPTH);
        lRdyExp = rdyIn && (lsbQ.size() < DEPTH);
        checkOutput({tag, ".aluReady"}, 64'(bus.alu_ready), 64'(aRdyExp));
        checkOutput({tag, ".lsbReady"}, 64'(bus.lsb_ready), 64'(lRdyExp));
        if (rdyIn) begin
            if (rbIn) begin
                aluQ.delete();
                lsbQ.delete();
                expValid = 1'b0;
            end else begin
                aAcc = aV && aRdyExp;
                lAcc = lV && lRdyExp;
                if (aAcc) begin
                    e = '{rob: ROB_W'(aRob), val: DW'(aVal), jump: aJ, pc: DW'(aPc)};
                    aluQ.push_back(e);
                end
                if (lAcc) begin
                    e = '{rob: ROB_W'(lRob), val: DW'(lVal), jump: 1'b0, pc: '0};
                    lsbQ.push_back(e);
                end
                if (aluQ.size() > 0 && lsbQ.size() > 0) begin
                    pickLsb    = !lastWasLsb;
                    lastWasLsb = pickLsb;
                    if (expCnt < 16'hFFFF) expCnt++;
                end else begin
                    pickLsb = (lsbQ.size() > 0);
                end
                expValid = (aluQ.size() > 0) || (lsbQ.size() > 0);
                if (expValid) begin
                    expSrc   = pickLsb;
                    expEntry = pickLsb ? lsbQ.pop_front() : aluQ.pop_front();
                end
            end
        end
        @(posedge clk);
        #1;
        checkBus(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tag, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        rstN = 1'b0;
        rdy = 1'b1;
        rollback = 1'b0;
        bus.alu_valid = 1'b0; bus.alu_rob_pos = '0; bus.alu_val = '0; bus.alu_jump = 1'b0; bus.alu_pc = '0;
        bus.lsb_valid = 1'b0; bus.lsb_rob_pos = '0; bus.lsb_val = '0;
        resetModel();
        #12;
        checkBus("reset");
        checkOutput("reset.aluReady", 64'(bus.alu_ready), 64'd1);
        checkOutput("reset.lsbReady", 64'(bus.lsb_ready), 64'd1);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single ALU result with bypass");
        applyStimulus("single", 1, 3, 'h1234, 1, 'h100, 0, 0, 0, 1, 0);
        checkOutput("single.tag", 64'(bus.cdb_rob_pos), 64'd3);
        idle("singleIdle", 1);

        $display("[TB] simultaneous first conflict");
        applyStimulus("conflict0", 1, 1, 'h11, 0, 'h40, 1, 2, 'h22, 1, 0);
        checkOutput("conflict0.src", 64'(bus.cdb_src), 64'd1);
        idle("conflict1", 2);
        checkOutput("conflict.cnt", 64'(bus.conflict_cnt), 64'd1);

        $display("[TB] ALU back-to-back");
        for (int t = 4; t <= 6; t++) applyStimulus("b2b", 1, t, t * 16, 0, t * 4, 0, 0, 0, 1, 0);
        idle("b2bIdle", 1);

        $display("[TB] fill both queues and drain");
        for (int t = 0; t < 8; t++) applyStimulus("fill", 1, t, 'hA00 + t, t[0], 'h200 + t, 1, t + 8, 'hB00 + t, 1, 0);
        idle("drain", 5);

        $display("[TB] rollback with queued results");
        for (int t = 0; t < 3; t++) applyStimulus("preRb", 1, t, t, 0, t, 1, t, t + 1, 1, 0);
        applyStimulus("rollback", 1, 9, 9, 1, 9, 1, 9, 9, 1, 1);
        checkOutput("rollback.valid", 64'(bus.cdb_valid), 64'd0);
        idle("postRb", 2);

        $display("[TB] rdy held low");
        for (int t = 0; t < 4; t++) applyStimulus("preFreeze", 1, t + 2, t + 'h50, 1, t, 1, t + 3, t + 'h60, 1, 0);
        for (int t = 0; t < 5; t++) applyStimulus("freeze", 1, 15, 'hFF, 1, 'hFF, 1, 14, 'hEE, 0, 0);
        idle("resume", 5);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom),
                          1'($urandom_range(0, 1)), int'($urandom),
                          1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom),
                          $urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0);
        end

        $display("[TB] asynchronous reset mid-operation");
        for (int t = 0; t < 3; t++) applyStimulus("preRst", 1, t, t + 7, 1, t + 1, 1, t, t + 5, 1, 0);
        bus.alu_valid = 1'b0;
        bus.lsb_valid = 1'b0;
        rstN = 1'b0;
        #1;
        resetModel();
        checkBus("midReset");
        checkOutput("midReset.aluReady", 64'(bus.alu_ready), 64'd1);
        checkOutput("midReset.lsbReady", 64'(bus.lsb_ready), 64'd1);
        #2;
        rstN = 1'b1;
        applyStimulus("postRst", 1, 7, 'h77, 0, 'h70, 1, 8, 'h88, 1, 0);
        idle("postRstIdle", 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter ROB_POS_W, default 4: ROB position width.
REQ-002 Parameter DATA_W, default 32: result and PC width.
REQ-003 Parameter DEPTH, default 2: per-source queue depth, power of two.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 rdy  in  1  global run enable; low freezes all state.
REQ-007 rollback  in  1  ROB misprediction flush.
REQ-008 alu_valid  in  1  ALU result offered.
REQ-009 alu_ready  out  1  ALU queue can accept.
REQ-010 alu_rob_pos  in  ROB_POS_W  ALU tag; alu_val in DATA_W; alu_jump in 1; alu_pc in DATA_W.
REQ-011 lsb_valid  in  1  load result offered.
REQ-012 lsb_ready  out  1  LSB queue can accept.
REQ-013 lsb_rob_pos  in  ROB_POS_W  LSB tag; lsb_val in DATA_W.
REQ-014 cdb_valid  out  1  broadcast strobe, one cycle per result.
REQ-015 cdb_src  out  1  0 = ALU, 1 = LSB.
REQ-016 cdb_rob_pos out ROB_POS_W; cdb_val out DATA_W; cdb_jump out 1; cdb_pc out DATA_W; all registered.
REQ-017 conflict_cnt  out  16  cycles where both sources were eligible, saturating.

Function
REQ-018 The block SHALL serialise ALU and LSB results onto one broadcast bus: at most one result per cycle.
REQ-019 Handshake: a result SHALL be accepted on an edge where valid && ready && rdy && !rollback.
REQ-020 The ready outputs SHALL be combinational from queue occupancy only: ready = (count < DEPTH); a same-cycle pop does not raise ready.
REQ-021 Each source SHALL own a FIFO of DEPTH entries with wrapping read/write pointers and a count of 0..DEPTH.
REQ-022 Eligibility: a source SHALL be eligible when its FIFO is non-empty, or when its FIFO is empty and a result is accepted that cycle (bypass).
REQ-023 Bypass latency SHALL be exactly one cycle: acceptance at edge N drives cdb_valid high after edge N.
REQ-024 The FIFO head SHALL always win over a same-source incoming result; that incoming result is pushed, preserving per-source order.
REQ-025 Arbitration state SHALL be one bit, last_grant; with both sources eligible, the source not last granted wins; after reset, LSB wins the first conflict.
REQ-026 last_grant SHALL update only on a grant made while both sources were eligible.
REQ-027 The loser of a conflict SHALL keep its head entry, or push its bypassed result, without loss.
REQ-028 cdb_valid SHALL be 0 on any edge with no eligible source; the other cdb_* outputs hold their last values.
REQ-029 cdb_jump and cdb_pc SHALL be 0 when cdb_src = 1.
REQ-030 conflict_cnt SHALL increment by one on each edge with both sources eligible, and stick at 0xFFFF.
REQ-031 With rdy low: FIFOs, pointers, last_grant, conflict_cnt and all cdb_* registers SHALL hold; ready outputs are 0.
REQ-032 On rollback with rdy high, the next edge SHALL empty both FIFOs, clear cdb_valid and discard same-cycle inputs; last_grant and conflict_cnt are kept.

Reset
REQ-033 Asserting rst SHALL immediately clear FIFO pointers and counts, last_grant, conflict_cnt and all cdb_* outputs to 0, mid-operation included.
REQ-034 After reset, alu_ready and lsb_ready SHALL be 1.

Structure
REQ-035 ROB_POS_W, DATA_W and the source encodings SRC_ALU = 0 and SRC_LSB = 1 SHALL live in the shared macro/package file.
REQ-036 One sub-module, result_fifo (parameterised width and depth, push/pop/count, async active-low reset), SHALL be instantiated twice.

Verification
REQ-037 Single ALU result (tag 3, val 0x1234, jump 1, pc 0x100), both FIFOs empty -> next cycle cdb_valid = 1, src 0, tag 3, val 0x1234; following cycle cdb_valid = 0.
REQ-038 ALU tag 1 and LSB tag 2 offered in the same cycle after reset -> LSB tag 2 broadcast first, ALU tag 1 next cycle; conflict_cnt = 1.
REQ-039 LSB idle, ALU offers tags 4, 5, 6 back-to-back -> broadcast 4, 5, 6 on consecutive cycles; alu_ready never drops.
REQ-040 Both sources queue DEPTH entries each -> both ready signals 0, broadcast grants alternate LSB/ALU until both queues drain.
REQ-041 Rollback pulsed with 3 results queued -> no cdb_valid next cycle, both counts 0, both ready signals 1.
REQ-042 rdy held low for 5 cycles with queued results -> outputs frozen, no pops, no pushes; broadcasts resume from the same entries once rdy returns high.
